// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: d-cache refill, load-use, branch.
// Define PIPE_PERF_CNT_EN to add the miss_stall_cycles/hazard_bubbles counters.
module pipeline_hazard_ctrl #(
   parameter int MISS_TIMEOUT = 255,
   parameter int CNT_W        = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mem_access,
   input  logic       dcache_hit,
   input  logic       mem_ack,
   input  logic       idex_mem_read,
   input  logic [4:0] idex_rt,
   input  logic [4:0] ifid_rs,
   input  logic [4:0] ifid_rt,
   input  logic       ifid_uses_rt,
   input  logic       branch_taken,
   output logic       pc_en,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       exmem_en,
   output logic       memwb_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       mem_req,
   output logic       bus_error
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0] miss_stall_cycles,
   output logic [31:0] hazard_bubbles
`endif
);

   localparam logic [1:0] S_RUN       = 2'd0;
   localparam logic [1:0] S_MISS_WAIT = 2'd1;
   localparam logic [1:0] S_REFILL    = 2'd2;
   localparam logic [1:0] S_ERROR     = 2'd3;

   localparam logic [CNT_W-1:0] TMO = CNT_W'(MISS_TIMEOUT);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             bubble_q;
   logic             miss;
   logic             hazard;
   logic             bubble;
   logic [4:0]       en;

   assign miss   = mem_access & ~dcache_hit;
   assign hazard = idex_mem_read & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) |
                    (ifid_uses_rt & (idex_rt == ifid_rt)));

   // bubble_q: ID/EXE holds the bubble just inserted, so the same
   // IF/ID instruction must not be stalled a second time.
   always_comb begin
      en         = 5'b00000;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      bubble     = 1'b0;
      if (!rst_n) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (state == S_RUN && !miss) begin
         if (branch_taken) begin
            en         = 5'b11111;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (hazard && !bubble_q) begin
            en         = 5'b00111;
            idex_flush = 1'b1;
            bubble     = 1'b1;
         end else begin
            en = 5'b11111;
         end
      end
   end

   assign pc_en     = en[4];
   assign ifid_en   = en[3];
   assign idex_en   = en[2];
   assign exmem_en  = en[1];
   assign memwb_en  = en[0];
   assign mem_req   = (state == S_MISS_WAIT);
   assign bus_error = (state == S_ERROR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_RUN;
         cnt      <= '0;
         bubble_q <= 1'b0;
      end else begin
         unique case (state)
            S_RUN: begin
               if (miss) begin
                  state <= S_MISS_WAIT;
                  cnt   <= '0;
               end else begin
                  bubble_q <= bubble;
               end
            end
            S_MISS_WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (mem_ack)
                  state <= S_REFILL;
               else if (cnt == TMO)
                  state <= S_ERROR;
            end
            S_REFILL: state <= S_RUN;
            default:  state <= state;
         endcase
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         miss_stall_cycles <= '0;
         hazard_bubbles    <= '0;
      end else begin
         if ((state == S_MISS_WAIT || state == S_REFILL) &&
             miss_stall_cycles != 32'hFFFF_FFFF)
            miss_stall_cycles <= miss_stall_cycles + 32'd1;
         if (bubble && hazard_bubbles != 32'hFFFF_FFFF)
            hazard_bubbles <= hazard_bubbles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus
// checked each negedge against a behavioural model of the controller.
module tb_pipeline_hazard_ctrl;

   localparam int TMO = 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_access = 1'b0;
   logic       dcache_hit = 1'b1;
   logic       mem_ack = 1'b0;
   logic       idex_mem_read = 1'b0;
   logic [4:0] idex_rt = 5'd0;
   logic [4:0] ifid_rs = 5'd0;
   logic [4:0] ifid_rt = 5'd0;
   logic       ifid_uses_rt = 1'b0;
   logic       branch_taken = 1'b0;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, mem_req, bus_error;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] miss_stall_cycles, hazard_bubbles;
`endif

   int compared = 0;
   int mismatched = 0;

   pipeline_hazard_ctrl #(.MISS_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mem_access(mem_access),
      .dcache_hit(dcache_hit), .mem_ack(mem_ack),
      .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .ifid_uses_rt(ifid_uses_rt), .branch_taken(branch_taken),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .mem_req(mem_req), .bus_error(bus_error)
`ifdef PIPE_PERF_CNT_EN
      , .miss_stall_cycles(miss_stall_cycles),
      .hazard_bubbles(hazard_bubbles)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: which phase the controller is in and how long
   // it has waited for memory.
   typedef enum int {M_RUN, M_WAIT, M_REFILL, M_ERR} mode_t;
   mode_t       mode = M_RUN;
   int          waited = 0;
   bit          bubble_pending = 1'b0;
   bit          model_ok = 1'b0;
   logic [31:0] stall_cnt = 0;
   logic [31:0] bub_cnt = 0;

   function automatic bit m_miss();
      return mem_access && !dcache_hit;
   endfunction

   function automatic bit m_hazard();
      bit reads_it;
      reads_it = (ifid_rs == idex_rt) || (ifid_uses_rt && ifid_rt == idex_rt);
      return idex_mem_read && idex_rt != 0 && reads_it;
   endfunction

   function automatic logic [8:0] expect_vec();
      logic [4:0] e;
      logic [1:0] f;
      if (!rst_n) begin
         e = 5'b00000; f = 2'b11;
      end else if (mode != M_RUN || m_miss()) begin
         e = 5'b00000; f = 2'b00;
      end else if (branch_taken) begin
         e = 5'b11111; f = 2'b11;
      end else if (m_hazard() && !bubble_pending) begin
         e = 5'b00111; f = 2'b01;
      end else begin
         e = 5'b11111; f = 2'b00;
      end
      return {e, f, mode == M_WAIT, mode == M_ERR};
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         mode <= M_RUN;
         waited <= 0;
         bubble_pending <= 1'b0;
         stall_cnt <= 0;
         bub_cnt <= 0;
         model_ok <= 1'b1;
      end else if (model_ok) begin
         case (mode)
            M_RUN: begin
               if (m_miss()) begin
                  mode <= M_WAIT;
                  waited <= 0;
               end else if (branch_taken) begin
                  bubble_pending <= 1'b0;
               end else if (m_hazard() && !bubble_pending) begin
                  bubble_pending <= 1'b1;
                  if (bub_cnt != 32'hFFFF_FFFF) bub_cnt <= bub_cnt + 1;
               end else begin
                  bubble_pending <= 1'b0;
               end
            end
            M_WAIT: begin
               if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1;
               waited <= waited + 1;
               if (mem_ack) mode <= M_REFILL;
               else if (waited + 1 > TMO) mode <= M_ERR;
            end
            M_REFILL: begin
               if (stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 1;
               mode <= M_RUN;
            end
            default: mode <= mode;
         endcase
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("outputs",
             {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
              ifid_flush, idex_flush, mem_req, bus_error},
             {23'd0, expect_vec()});
`ifdef PIPE_PERF_CNT_EN
         chk("miss_stall_cycles", miss_stall_cycles, stall_cnt);
         chk("hazard_bubbles", hazard_bubbles, bub_cnt);
`endif
      end
   end

   initial begin
      int n;
      // reset held two cycles
      @(negedge clk);
      chk("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      chk("rst_flush", {ifid_flush, idex_flush}, 2'b11);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_bus_error", bus_error, 1'b0);
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk("run_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
      chk("run_flush", {ifid_flush, idex_flush}, 2'b00);

      // miss in cycle 0, ack in cycle 5, refill in cycle 6
      nxt();
      mem_access = 1'b1;
      dcache_hit = 1'b0;
      @(negedge clk);
      chk("miss_c0_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      chk("miss_c0_req", mem_req, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         nxt();
         mem_ack = (i == 5);
         if (i == 6) dcache_hit = 1'b1;
         @(negedge clk);
         chk("miss_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
         chk("miss_req", mem_req, (i <= 5));
      end
      nxt();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("miss_c7_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
      nxt();
      mem_access = 1'b0;

      // load-use through rs: one bubble only
      idex_mem_read = 1'b1;
      idex_rt = 5'd8;
      ifid_rs = 5'd8;
      ifid_rt = 5'd3;
      @(negedge clk);
      chk("lu_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
      chk("lu_rest", {idex_en, exmem_en, memwb_en, ifid_flush}, 4'b1110);
      nxt();
      @(negedge clk);
      chk("lu_one_bubble", {pc_en, ifid_en, idex_flush}, 3'b110);
      nxt();
      idex_rt = 5'd0;
      ifid_rs = 5'd0;
      @(negedge clk);
      chk("lu_r0", {pc_en, ifid_en, idex_flush}, 3'b110);
      nxt();
      idex_rt = 5'd5;
      ifid_rs = 5'd1;
      ifid_rt = 5'd5;
      ifid_uses_rt = 1'b1;
      @(negedge clk);
      chk("lu_rt", {pc_en, ifid_en, idex_flush}, 3'b001);
      nxt();
      idex_mem_read = 1'b0;
      ifid_uses_rt = 1'b0;

      // branch beats load-use
      nxt();
      idex_mem_read = 1'b1;
      idex_rt = 5'd8;
      ifid_rs = 5'd8;
      branch_taken = 1'b1;
      @(negedge clk);
      chk("br_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
      chk("br_flush", {ifid_flush, idex_flush}, 2'b11);
      nxt();
      branch_taken = 1'b0;
      idex_mem_read = 1'b0;

      // timeout with no ack
      mem_access = 1'b1;
      dcache_hit = 1'b0;
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (bus_error) break;
         if (mem_req) n++;
         nxt();
      end
      chk("timeout_cycles", n, TMO + 1);
      chk("timeout_err", bus_error, 1'b1);
      nxt();
      mem_access = 1'b0;
      mem_ack = 1'b1;
      @(negedge clk);
      chk("err_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      nxt();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("err_sticky", {bus_error, mem_req}, 2'b10);
      nxt();
      rst_n = 1'b0;
      nxt();
      rst_n = 1'b1;
      @(negedge clk);
      chk("err_cleared", bus_error, 1'b0);
      chk("err_run_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);

      // reset in the middle of a miss
      nxt();
      mem_access = 1'b1;
      dcache_hit = 1'b0;
      nxt();
      nxt();
      nxt();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rmid_req", mem_req, 1'b1);
      chk("rmid_flush", {ifid_flush, idex_flush, pc_en}, 3'b110);
      nxt();
      rst_n = 1'b1;
      mem_access = 1'b0;
      dcache_hit = 1'b1;
      @(negedge clk);
      chk("rmid_req_drop", mem_req, 1'b0);
      chk("rmid_run", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
`ifdef PIPE_PERF_CNT_EN
      chk("rmid_perf", miss_stall_cycles, 32'd0);
`endif

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         nxt();
         rst_n = ($urandom_range(0, 299) != 0);
         mem_access = ($urandom_range(0, 2) == 0);
         dcache_hit = ($urandom_range(0, 3) != 0);
         mem_ack = ($urandom_range(0, 7) == 0);
         idex_mem_read = 1'($urandom);
         idex_rt = 5'($urandom_range(0, 3));
         ifid_rs = 5'($urandom_range(0, 3));
         ifid_rt = 5'($urandom_range(0, 3));
         ifid_uses_rt = 1'($urandom);
         branch_taken = ($urandom_range(0, 5) == 0);
      end
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
